// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one MFA/MFC RAM port between fetch and data.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: data wins).
module ram_access_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [1:0]        ramDataSize,
  output logic [DATA_W-1:0] ramDataOut,
  input  logic [DATA_W-1:0] ramDataIn,
  input  logic              ramMFC
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    COMPLETE,
    ERROR,
    RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                win_q, win_d;
  logic                mfa_q, mfa_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                f_done_q, f_done_d;
  logic                f_err_q, f_err_d;
  logic                d_done_q, d_done_d;
  logic                d_err_q, d_err_d;
  logic                busy_q, busy_d;
  logic                pick_data;

`ifdef MEM_ARB_RR_EN
  // last_q: 1 when data was granted last, 0 when fetch was
  logic                last_q, last_d;

  // on a tie, the requester granted last yields
  assign pick_data = d_req & (~f_req | ~last_q);
`else
  // data always beats fetch
  assign pick_data = d_req;
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    mfa_d    = mfa_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    f_done_d = 1'b0;
    f_err_d  = 1'b0;
    d_done_d = 1'b0;
    d_err_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (f_req | d_req) begin
          win_d   = pick_data;
          cnt_d   = '0;
          mfa_d   = 1'b1;
          state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_data;
`endif
          if (pick_data) begin
            rw_d    = d_rw;
            addr_d  = d_addr;
            size_d  = d_size;
            wdata_d = d_wdata;
          end else begin
            rw_d    = 1'b0;
            addr_d  = f_addr;
            size_d  = 2'b11;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (ramMFC) begin
          if (!rw_q) begin
            rdata_d = ramDataIn;
          end
          mfa_d   = 1'b0;
          state_d = COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          mfa_d   = 1'b0;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPLETE: begin
        d_done_d = win_q;
        f_done_d = ~win_q;
        state_d  = RELEASE;
      end
      ERROR: begin
        d_err_d = win_q;
        f_err_d = ~win_q;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!ramMFC) begin
          state_d = IDLE;
        end
      end
      default: begin
        mfa_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      mfa_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      f_done_q <= 1'b0;
      f_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      mfa_q    <= mfa_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      f_done_q <= f_done_d;
      f_err_q  <= f_err_d;
      d_done_q <= d_done_d;
      d_err_q  <= d_err_d;
      busy_q   <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign f_done      = f_done_q;
  assign f_err       = f_err_q;
  assign d_done      = d_done_q;
  assign d_err       = d_err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign ramMFA      = mfa_q;
  assign ramRW       = rw_q;
  assign ramAddress  = addr_q;
  assign ramDataSize = size_q;
  assign ramDataOut  = wdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: scoreboard bench for ram_access_arbiter.
// Random requests against a transaction-level model and a RAM responder.
module tb_ram_access_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_done, f_err;
  logic          d_req = 1'b0;
  logic          d_rw = 1'b0;
  logic [1:0]    d_size = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done, d_err;
  logic [DW-1:0] rdata;
  logic          busy, ramMFA, ramRW;
  logic [AW-1:0] ramAddress;
  logic [1:0]    ramDataSize;
  logic [DW-1:0] ramDataOut;
  logic [DW-1:0] ramDataIn = '0;
  logic          ramMFC = 1'b0;

  ram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr),
    .f_done(f_done), .f_err(f_err),
    .d_req(d_req), .d_rw(d_rw),
    .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err),
    .rdata(rdata), .busy(busy),
    .ramMFA(ramMFA), .ramRW(ramRW),
    .ramAddress(ramAddress),
    .ramDataSize(ramDataSize),
    .ramDataOut(ramDataOut),
    .ramDataIn(ramDataIn), .ramMFC(ramMFC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit            is_d;
    bit            ok;
    logic          rw;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            mfa_cyc;
  } exp_t;

  typedef struct {
    int            delay;
    logic [DW-1:0] data;
    int            hold;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    mon_en = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  bit    m_last_d = 1'b0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endfunction

  // model: one serviced access, in service order
  function automatic void push_one(bit is_d, int dl,
                                   logic [DW-1:0] dat, int hold);
    exp_t  e;
    plan_t p;
    e.is_d    = is_d;
    e.ok      = (dl <= TO);
    e.rw      = is_d ? d_rw : 1'b0;
    e.addr    = is_d ? d_addr : f_addr;
    e.size    = is_d ? d_size : 2'b11;
    e.wdata   = d_wdata;
    e.mfa_cyc = e.ok ? dl : TO;
    if (e.ok && !e.rw) m_rdata = dat;
    e.rdata   = m_rdata;
    m_last_d  = is_d;
    p.delay   = dl;
    p.data    = dat;
    p.hold    = hold;
    exp_q.push_back(e);
    plan_q.push_back(p);
  endfunction

  // RAM responder: answers each access after its planned delay
  plan_t r_p;
  int    r_cnt = 0;
  int    r_hold = 0;
  bit    r_act = 1'b0;
  always @(negedge Clk) begin
    if (!reset) begin
      ramMFC = 1'b0;
      r_act  = 1'b0;
    end else if (r_act) begin
      if (ramMFC) begin
        if (!ramMFA) begin
          if (r_hold == 0) begin
            ramMFC = 1'b0;
            r_act  = 1'b0;
          end else begin
            r_hold--;
          end
        end
      end else if (!ramMFA) begin
        r_act = 1'b0;
      end else begin
        r_cnt++;
        if (r_cnt == r_p.delay) begin
          ramMFC    = 1'b1;
          ramDataIn = r_p.data;
        end
      end
    end else if (ramMFA && plan_q.size() != 0) begin
      r_p    = plan_q.pop_front();
      r_hold = r_p.hold;
      r_cnt  = 1;
      r_act  = 1'b1;
      if (r_p.delay == 1) begin
        ramMFC    = 1'b1;
        ramDataIn = r_p.data;
      end
    end
    if (!ramMFC) ramDataIn = $urandom();
  end

  // monitor: compares grants and responses against the scoreboard
  bit         prev_mfa = 1'b0;
  bit         prev_mfc = 1'b0;
  bit         pulse_chk = 1'b0;
  int         mfa_len = 0;
  exp_t       m_e;
  logic [3:0] kind;
  always @(posedge Clk) begin
    #2;
    if (mon_en) begin
      if (pulse_chk) begin
        chk("pulse_width", 64'({f_done, f_err, d_done, d_err}), 64'(0));
        pulse_chk = 1'b0;
      end
      if (ramMFA && !prev_mfa) begin
        chk("grant_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          chk("ramAddress", 64'(ramAddress), 64'(exp_q[0].addr));
          chk("ramRW", 64'(ramRW), 64'(exp_q[0].rw));
          chk("ramDataSize", 64'(ramDataSize), 64'(exp_q[0].size));
          if (exp_q[0].rw)
            chk("ramDataOut", 64'(ramDataOut), 64'(exp_q[0].wdata));
          chk("mfc_low_at_grant", 64'(prev_mfc), 64'(0));
          chk("busy", 64'(busy), 64'(1));
        end
        mfa_len = 1;
      end else if (ramMFA) begin
        mfa_len++;
      end
      if (!ramMFA && prev_mfa && exp_q.size() != 0)
        chk("mfa_cycles", 64'(mfa_len), 64'(exp_q[0].mfa_cyc));
      if (f_done | f_err | d_done | d_err) begin
        pulse_chk = 1'b1;
        chk("resp_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          m_e  = exp_q.pop_front();
          kind = m_e.is_d ? (m_e.ok ? 4'b0010 : 4'b0001)
                          : (m_e.ok ? 4'b1000 : 4'b0100);
          chk("resp_kind", 64'({f_done, f_err, d_done, d_err}),
              64'(kind));
          chk("rdata", 64'(rdata), 64'(m_e.rdata));
        end
      end
    end
    prev_mfa = ramMFA;
    prev_mfc = ramMFC;
  end

  // requesters drop req on their own done/err
  task automatic drain(int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge Clk);
      if (f_done | f_err) f_req = 1'b0;
      if (d_done | d_err) d_req = 1'b0;
      c++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    if (exp_q.size() != 0) begin
      exp_q.delete();
      plan_q.delete();
      f_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic issue(bit f, bit d,
                       int fdl, logic [DW-1:0] fdat, int fh,
                       int ddl, logic [DW-1:0] ddat, int dh);
    bit d_first;
`ifdef MEM_ARB_RR_EN
    d_first = !m_last_d;
`else
    d_first = 1'b1;
`endif
    if (d && (d_first || !f)) begin
      push_one(1'b1, ddl, ddat, dh);
      if (f) push_one(1'b0, fdl, fdat, fh);
    end else if (f) begin
      push_one(1'b0, fdl, fdat, fh);
      if (d) push_one(1'b1, ddl, ddat, dh);
    end
    f_req = f;
    d_req = d;
    drain(400);
  endtask

  initial begin
    int c;
    bit rf, rd;
    #1 reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ctrl", 64'({f_done, f_err, d_done, d_err,
                         busy, ramMFA, ramRW}), 64'(0));
    chk("rst_addr", 64'(ramAddress), 64'(0));
    chk("rst_size", 64'(ramDataSize), 64'(0));
    chk("rst_wdata", 64'(ramDataOut), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge Clk);

    // reset in the middle of an access, fetch kept requesting
    f_addr = 9'h1A5;
    plan_q.push_back('{99, 32'h0, 0});
    f_req = 1'b1;
    c = 0;
    while (!ramMFA && c < 20) begin
      @(negedge Clk);
      c++;
    end
    chk("abort_grant", 64'(ramMFA), 64'(1));
    repeat (3) @(negedge Clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_mfa", 64'(ramMFA), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    plan_q.delete();
    m_rdata  = '0;
    m_last_d = 1'b0;
    repeat (2) @(negedge Clk);
    mon_en = 1'b1;
    push_one(1'b0, 2, 32'h1234_5678, 1);
    reset = 1'b1;
    drain(100);

    // plain fetch
    f_addr = 9'h010;
    issue(1, 0, 3, 32'h8C22_0004, 0, 0, 32'h0, 0);

    // simultaneous write and fetch
    d_rw = 1'b1; d_addr = 9'h040;
    d_wdata = 32'hDEAD_BEEF; d_size = 2'b11;
    f_addr = 9'h011;
    issue(1, 1, 2, 32'h0000_1111, 1, 2, 32'h0, 0);

    // timeout, then response on the last allowed cycle
    d_rw = 1'b0; d_addr = 9'h0AB; d_size = 2'b10;
    issue(0, 1, 0, 32'h0, 0, TO + 1, 32'h0BAD_0BAD, 0);
    issue(0, 1, 0, 32'h0, 0, TO, 32'hCAFE_F00D, 0);
    issue(1, 0, TO + 1, 32'h5555_AAAA, 0, 0, 32'h0, 0);

    // long MFC hold with data already waiting
    f_addr = 9'h033;
    issue(1, 0, 1, 32'h0F0F_0F0F, 4, 0, 32'h0, 0);
    d_addr = 9'h034;
    issue(0, 1, 0, 32'h0, 0, 1, 32'hA5A5_5A5A, 4);

    // ties back to back
    repeat (4) issue(1, 1, 1, $urandom(), 0, 2, $urandom(), 1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      rf = 1'($urandom_range(0, 1));
      rd = rf ? 1'($urandom_range(0, 1)) : 1'b1;
      f_addr  = AW'($urandom());
      d_addr  = AW'($urandom());
      d_rw    = 1'($urandom_range(0, 1));
      d_size  = 2'($urandom());
      d_wdata = $urandom();
      issue(rf, rd,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO + 2))
                                        : int'($urandom_range(1, 4)),
            $urandom(), int'($urandom_range(0, 4)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO + 2))
                                        : int'($urandom_range(1, 4)),
            $urandom(), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (10) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
